// File: rtl/a_feed_if.sv
// ----------------------------------------------------------------------------
// A : generic single-field interface carrying one WIDTH-bit word `x`.
//
// Parameters
//   WIDTH : width of x
// Modports
//   src : driver side (a_feed drives x)
//   snk : consumer side (reads x)
// ----------------------------------------------------------------------------
interface A #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] x;

  modport src (output x);
  modport snk (input  x);
endinterface

// File: rtl/a_feed.sv
// ----------------------------------------------------------------------------
// a_feed : registered FIFO source stage feeding the x field of an A interface.
//
// Upstream pushes words. Each downstream advance strobe (rd_en) pops the
// oldest word onto a.x, where it holds until the next pop. There is no
// bypass: a word written on one edge can reach a.x at the earliest on the
// following edge.
//
// Parameters
//   WIDTH : word width (must match the bound A instance)
//   DEPTH : FIFO entries, power of two, >= 2
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   wr_en   in   push request
//   wr_data in   push word
//   rd_en   in   advance strobe from the consumer
//   full    out  FIFO holds DEPTH words
//   empty   out  FIFO holds 0 words
//   count   out  occupancy
//   drops   out  saturating count of rejected pushes
//   csum    out  running XOR of every word popped to a.x
//   a       if   A.src, sole driver of a.x
// Configuration macro
//   A_FEED_CSUM_EN : when defined, csum is a live register; otherwise it is
//                    tied to zero and no register is built.
// ----------------------------------------------------------------------------
module a_feed #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drops,
  output logic [WIDTH-1:0]         csum,
  A.src                            a
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } st_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic [7:0]       r_drops;
  st_t              r_st;
  st_t              w_st_next;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign drops = r_drops;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // when the consumer advances.
  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);
  assign w_drop = wr_en && full && !w_pop;

  // NOTE: the storage array carries no reset; stale entries are unreachable
  // because the pointers and count are reset, and leaving it out lets the
  // array map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drops <= '0;
      a.x     <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        a.x    <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drops != 8'hFF)) begin
        r_drops <= r_drops + 1'b1;
      end
    end
  end

`ifdef A_FEED_CSUM_EN
  logic [WIDTH-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ r_mem[r_rptr];
    end
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= ST_IDLE;
    end else begin
      r_st <= w_st_next;
    end
  end

  // NOTE: the default assignment first keeps this block free of latches on
  // any path that does not change state.
  always_comb begin
    w_st_next = r_st;
    case (r_st)
      ST_IDLE: begin
        if (w_push) begin
          w_st_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Last word leaves with nothing arriving to replace it.
        if (w_pop && !w_push && (r_count == {{PW{1'b0}}, 1'b1})) begin
          w_st_next = ST_IDLE;
        end
      end
      default: w_st_next = ST_IDLE;
    endcase
  end

  a_empty_matches_idle : assert property (@(posedge clk) empty == (r_st == ST_IDLE));

endmodule

// File: tb/tb_a_feed.sv
// ----------------------------------------------------------------------------
// tb_a_feed : self-checking bench for a_feed (WIDTH=32, DEPTH=4).
// The reference model is a word queue plus scalar registers for a.x, drops
// and csum, updated from the FIFO rules once per clock edge.
// ----------------------------------------------------------------------------
module tb_a_feed;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic [7:0]       drops;
  logic [WIDTH-1:0] csum;

  A #(.WIDTH(WIDTH)) u_a ();

  a_feed #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .drops   (drops),
    .csum    (csum),
    .a       (u_a)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_ax;
  int               m_drops;
  logic [WIDTH-1:0] m_csum;

  function automatic logic [WIDTH-1:0] exp_csum();
`ifdef A_FEED_CSUM_EN
    return m_csum;
`else
    return '0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and
  // return 1 time unit after the edge so outputs have settled.
  task automatic step(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rd);
    bit p;
    bit pu;
    @(negedge clk);
    rst = r; wr_en = w; wr_data = d; rd_en = rd;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ax = '0; m_drops = 0; m_csum = '0;
    end else begin
      p  = rd && (m_q.size() != 0);
      pu = w && ((m_q.size() < DEPTH) || p);
      if (p) begin
        m_ax   = m_q.pop_front();
        m_csum = m_csum ^ m_ax;
      end
      if (pu) m_q.push_back(d);
      else if (w && (m_drops < 255)) m_drops++;
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (u_a.x !== '0)   begin n_errors++; $display("FAIL reset_ax: got %h exp 0", u_a.x); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0)  begin n_errors++; $display("FAIL reset_full: got %b exp 0", full); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_checks++; if (drops !== 8'd0) begin n_errors++; $display("FAIL reset_drops: got %0d exp 0", drops); end
    n_checks++; if (csum !== '0)    begin n_errors++; $display("FAIL reset_csum: got %h exp 0", csum); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp [3];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, exp[i], 1'b0);
    n_checks++; if (u_a.x !== '0) begin n_errors++; $display("FAIL basic_no_bypass: got %h exp 0", u_a.x); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n_checks++; if (u_a.x !== exp[i]) begin n_errors++; $display("FAIL basic_pop%0d: got %h exp %h", i, u_a.x, exp[i]); end
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (u_a.x !== 32'h33) begin n_errors++; $display("FAIL basic_hold: got %h exp 33", u_a.x); end
    n_checks++; if (empty !== 1'b1)   begin n_errors++; $display("FAIL basic_empty: got %b exp 1", empty); end
    n_checks++; if (csum !== '0)      begin n_errors++; $display("FAIL basic_csum: got %h exp 0", csum); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'hA0 + i, 1'b0);
    n_checks++; if (full !== 1'b1)  begin n_errors++; $display("FAIL ovf_full: got %b exp 1", full); end
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL ovf_count: got %0d exp 4", count); end
    n_checks++; if (drops !== 8'd2) begin n_errors++; $display("FAIL ovf_drops: got %0d exp 2", drops); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n_checks++; if (u_a.x !== 32'hA0 + i) begin n_errors++; $display("FAIL ovf_drain%0d: got %h exp %h", i, u_a.x, 32'hA0 + i); end
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL ovf_empty: got %b exp 1", empty); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hC0 + i, 1'b0);
    step(1'b0, 1'b1, 32'hB0, 1'b1);
    n_checks++; if (count !== 3'd4)    begin n_errors++; $display("FAIL simul_count: got %0d exp 4", count); end
    n_checks++; if (drops !== 8'd0)    begin n_errors++; $display("FAIL simul_drops: got %0d exp 0", drops); end
    n_checks++; if (u_a.x !== 32'hC0)  begin n_errors++; $display("FAIL simul_ax: got %h exp C0", u_a.x); end
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (u_a.x !== 32'hB0)  begin n_errors++; $display("FAIL simul_last: got %h exp B0", u_a.x); end
    n_checks++; if (csum !== exp_csum()) begin n_errors++; $display("FAIL simul_csum: got %h exp %h", csum, exp_csum()); end
  endtask

  task automatic test_wrap();
    do_reset();
    // Pushing and popping together: the first pop finds the FIFO empty,
    // so a.x lags the pushed stream by one cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h100 + i, 1'b1);
      if (i > 0) begin
        n_checks++; if (u_a.x !== 32'h100 + i - 1) begin n_errors++; $display("FAIL wrap%0d: got %h exp %h", i, u_a.x, 32'h100 + i - 1); end
      end
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (u_a.x !== 32'h109) begin n_errors++; $display("FAIL wrap_last: got %h exp 109", u_a.x); end
    n_checks++; if (empty !== 1'b1)    begin n_errors++; $display("FAIL wrap_empty: got %b exp 1", empty); end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int i = 0; i < 4 + 260; i++) step(1'b0, 1'b1, $urandom, 1'b0);
    n_checks++; if (drops !== 8'd255) begin n_errors++; $display("FAIL sat_drops: got %0d exp 255", drops); end
    n_checks++; if (count !== 3'd4)   begin n_errors++; $display("FAIL sat_count: got %0d exp 4", count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hD0 + i, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    // Reset with push and pop also asserted: both must be ignored.
    step(1'b1, 1'b1, 32'hEE, 1'b1);
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL rstmid_count: got %0d exp 0", count); end
    n_checks++; if (u_a.x !== '0)   begin n_errors++; $display("FAIL rstmid_ax: got %h exp 0", u_a.x); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL rstmid_empty: got %b exp 1", empty); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (u_a.x !== '0)   begin n_errors++; $display("FAIL rstmid_rd: got %h exp 0", u_a.x); end
    n_checks++; if (csum !== '0)    begin n_errors++; $display("FAIL rstmid_csum: got %h exp 0", csum); end
  endtask

  task automatic test_random();
    bit r, w, rd;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 1) == 1);
      step(r, w, $urandom, rd);
      n_checks++; if (u_a.x !== m_ax) begin n_errors++; $display("FAIL rnd_ax@%0d: got %h exp %h", i, u_a.x, m_ax); end
      n_checks++; if (count !== 3'(m_q.size())) begin n_errors++; $display("FAIL rnd_count@%0d: got %0d exp %0d", i, count, m_q.size()); end
      n_checks++; if (full !== (m_q.size() == DEPTH)) begin n_errors++; $display("FAIL rnd_full@%0d: got %b", i, full); end
      n_checks++; if (empty !== (m_q.size() == 0)) begin n_errors++; $display("FAIL rnd_empty@%0d: got %b", i, empty); end
      n_checks++; if (drops !== 8'(m_drops)) begin n_errors++; $display("FAIL rnd_drops@%0d: got %0d exp %0d", i, drops, m_drops); end
      n_checks++; if (csum !== exp_csum()) begin n_errors++; $display("FAIL rnd_csum@%0d: got %h exp %h", i, csum, exp_csum()); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    m_ax = '0; m_drops = 0; m_csum = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_wrap();
    test_drop_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
